paralelo_serial: RTL and testbench
==================================

# paralelo_serial

Parallel-to-serial converter in the transmit path, downstream of the clock divider. It runs on the fast bit clock `clk`; the byte-rate domains (`clk10`/`clk20`/`clk40`) are generated from that same clock. The block accepts one byte per 8 bit-clocks through a valid/ready handshake and shifts it out MSB-first. When no byte is offered it inserts an idle symbol, so the line never stalls.

## Interface
- `WIDTH`, 8: word width; must be 8 in this design, counter sized as $clog2(WIDTH).
- `IDLE_SYM`, 8'hBC: symbol transmitted when no valid byte is offered at a word boundary.
- `clk`  in  1  bit clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enb`  in  1  enable; low freezes all state.
- `data_in`  in  WIDTH  byte to transmit.
- `valid`  in  1  `data_in` holds a byte to send.
- `ready`  out  1  block accepts `data_in` on this edge.
- `sout`  out  1  serial bit, MSB first.
- `frame`  out  1  high while `sout` carries bit 7 (first bit) of a word.
- `is_data`  out  1  high while the word on `sout` is user data, low while it is `IDLE_SYM`.

## Operation
- State registers:
  - `shift[WIDTH-1:0]`
  - bit counter `cnt[2:0]`
  - `active` flag (first word loaded)
  - `is_data` flag
- Reset (async, `rst`=0): `shift`=0, `cnt`=7, `active`=0, `is_data`=0. All outputs therefore reset low: `sout`=0, `frame`=0, `is_data`=0, `ready`=0 while in reset.
- `ready` = `enb` & (`cnt`==7), combinational. This is the only edge on which a byte transfers. A transfer occurs when `valid` & `ready`.
- Each rising edge with `enb`=1:
  - When `cnt`==7 (word boundary):
    - `cnt`<=0, `active`<=1.
    - If `valid`: `shift`<=`data_in`, `is_data`<=1.
    - Else: `shift`<=`IDLE_SYM`, `is_data`<=0.
  - Otherwise: `cnt`<=`cnt`+1, `shift`<=`shift`<<1 (zero fill). Wraps 7->0 only through the load path.
- `sout` = `shift[7]`.
- `frame` = `active` & (`cnt`==0).
- `valid` while `ready`=0 is ignored. The upstream must hold `data_in`/`valid` until it sees `ready`. No skid buffer.
- `enb`=0 mid-word: `shift`, `cnt` and flags hold; `sout`/`frame`/`is_data` hold their values; `ready`=0. Resuming `enb`=1 continues at the same bit.
- Reset asserted mid-word: the word is discarded immediately and outputs go to reset values. The first enabled edge after release is a word boundary (`cnt`=7).
- `valid` held high continuously gives back-to-back user bytes with no idle gap: throughput of 1 byte / 8 enabled clocks.

## Timing
- Latency: a byte accepted on edge N appears as bit 7 on `sout` immediately after edge N. Bit k (7..0) is on `sout` during the cycle after edge N+(7-k).
- `frame` pulses for one enabled cycle per word, coincident with bit 7.
- `ready` is high for exactly one cycle in every 8 enabled cycles, aligned to the last bit of the current word. It is not asserted in the reset state.
- The first enabled edge after reset release loads a word (user or idle), and `active` goes high.
- Word boundaries are fixed relative to enabled clock edges after reset. An external byte-rate clock derived from the same divider is phase-aligned only if both leave reset on the same edge.

## Structure
- Shared include/package `serdes_defs`: `WIDTH_BYTE`=8, `IDLE_SYM`=8'hBC, `CNT_W`=3. This is reused by the future `serial_paralelo` receiver for comma detection.
- One natural sub-module: `contador_bits`, a 3-bit counter with async active-low reset to 7, enable, and `last` (cnt==7) output. The shift register and flags stay in the top level.
- Target size: ~150 lines RTL plus a gate-level synthesized copy (`paralelo_serialSynth`) for the same bench.

## Test plan
- Reset then idle: hold `rst`=0 for 4 clocks, release, `valid`=0. Required: `sout`=0 during reset; afterwards a repeating stream 1,0,1,1,1,1,0,0 (0xBC); `frame` every 8th cycle; `is_data`=0.
- Single byte: offer `data_in`=8'hA5 with `valid`=1 until `ready`. Required: next 8 `sout` bits are 1,0,1,0,0,1,0,1 with `is_data`=1, followed by 0xBC with `is_data`=0.
- Back-to-back: with `valid` high continuously, send 8'h01, 8'hFF, 8'h80. Required: 24 bits 00000001 11111111 10000000, no idle gap, `ready` pulses on exactly 3 boundaries.
- Enable freeze: drop `enb` for 5 clocks after bit 4 of 8'hC3. Required: `sout`, `frame` and `cnt` hold and `ready`=0; after resume, remaining bits 0,0,1,1 follow with no loss.
- Reset mid-word: assert `rst` during bit 3 of 8'h5A. Required: `sout`=0 and `is_data`=0 immediately (async); after release the first word sent is 0xBC or the newly offered byte.
- RTL vs synthesized: run all of the above on `paralelo_serial` and `paralelo_serialSynth`. Required: identical `sout`/`frame`/`ready`/`is_data` every cycle.

Source files
------------

// File: rtl/serdes_defs_pkg.sv
// Shared serial-link constants for the transmit and receive sides.
`timescale 1ns/1ps
package serdes_defs;
  localparam int         WIDTH_BYTE = 8;
  localparam int         CNT_W      = 3;
  localparam logic [7:0] IDLE_SYM   = 8'hBC;

  // Comma detection helper for the receiver side.
  function automatic logic is_comma(input logic [WIDTH_BYTE-1:0] sym);
    return (sym == IDLE_SYM);
  endfunction
endpackage

// File: rtl/contador_bits.sv
// Bit-position counter: resets to the last position so the first enabled edge is a word boundary.
`timescale 1ns/1ps
module contador_bits #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enb_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance on enable, wrapping to zero after the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (enb_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_LAST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: one byte per 8 enabled bit clocks, MSB first,
// with the idle symbol inserted whenever no byte is offered at a word boundary.
`timescale 1ns/1ps
module paralelo_serial #(
  parameter int               WIDTH    = serdes_defs::WIDTH_BYTE,
  parameter logic [WIDTH-1:0] IDLE_SYM = serdes_defs::IDLE_SYM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             frame,
  output logic             is_data
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             active_q;
  logic             active_d;
  logic             is_data_q;
  logic             is_data_d;
  logic [CW-1:0]    cnt_s;
  logic             last_s;

  contador_bits #(
    .CNT_W (CW)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .enb_i  (enb),
    .cnt_o  (cnt_s),
    .last_o (last_s)
  );

  // Load a user byte or the idle symbol at the boundary, otherwise shift left.
  always_comb begin
    shift_d   = shift_q;
    active_d  = active_q;
    is_data_d = is_data_q;
    if (enb) begin
      if (last_s) begin
        active_d = 1'b1;
        if (valid) begin
          shift_d   = data_in;
          is_data_d = 1'b1;
        end else begin
          shift_d   = IDLE_SYM;
          is_data_d = 1'b0;
        end
      end else begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      shift_d = shift_q;
    end
  end

  // Shift register and word flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= {WIDTH{1'b0}};
      active_q  <= 1'b0;
      is_data_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      active_q  <= active_d;
      is_data_q <= is_data_d;
    end
  end

  // rst gates ready so the counter's reset value never looks like a boundary.
  assign ready   = enb & last_s & rst;
  assign sout    = shift_q[WIDTH-1];
  assign frame   = active_q & (cnt_s == {CW{1'b0}});
  assign is_data = is_data_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed, table-driven bench for paralelo_serial plus hand sequences for reset corners.
`timescale 1ns/1ps
module tb_paralelo_serial;

  logic       clk;
  logic       rst;
  logic       enb;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;
  logic       sout;
  logic       frame;
  logic       is_data;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       enb;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_sout;
    logic       exp_frame;
    logic       exp_is_data;
  } vec_t;

  vec_t vecs[$];

  paralelo_serial dut (
    .clk     (clk),
    .rst     (rst),
    .enb     (enb),
    .data_in (data_in),
    .valid   (valid),
    .ready   (ready),
    .sout    (sout),
    .frame   (frame),
    .is_data (is_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add_vec(input logic e, input logic v, input logic [7:0] d,
                                  input logic r, input logic s, input logic f, input logic isd);
    vec_t x;
    x.enb = e; x.valid = v; x.data = d;
    x.exp_ready = r; x.exp_sout = s; x.exp_frame = f; x.exp_is_data = isd;
    vecs.push_back(x);
  endfunction

  // Eight enabled cycles of one word; valid stays asserted on non-boundary cycles when v=1.
  function automatic void add_word(input logic v, input logic [7:0] d);
    logic [7:0] w;
    w = v ? d : 8'hBC;
    for (int i = 0; i < 8; i++) begin
      add_vec(1'b1, v, d, (i == 0), w[7-i], (i == 0), v);
    end
  endfunction

  initial begin
    logic [7:0] w;
    n_chk  = 0;
    n_fail = 0;

    // Build the vector table.
    add_word(1'b0, 8'h00);
    add_word(1'b0, 8'h00);
    add_word(1'b1, 8'hA5);
    add_word(1'b0, 8'h00);
    add_word(1'b1, 8'h01);
    add_word(1'b1, 8'hFF);
    add_word(1'b1, 8'h80);
    add_word(1'b0, 8'h00);
    // 8'hC3 = 1100_0011, frozen for 5 clocks after bit 4 goes out.
    add_vec(1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      add_vec(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    add_word(1'b0, 8'h00);

    // Reset held for 4 clocks with inputs active.
    rst = 1'b0; enb = 1'b1; valid = 1'b1; data_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_sout[%0d]", i), sout, 1'b0);
      chk($sformatf("rst_frame[%0d]", i), frame, 1'b0);
      chk($sformatf("rst_is_data[%0d]", i), is_data, 1'b0);
      chk($sformatf("rst_ready[%0d]", i), ready, 1'b0);
    end
    valid = 1'b0;
    rst   = 1'b1;

    // Apply the table: ready before the edge, serial outputs after it.
    foreach (vecs[i]) begin
      enb = vecs[i].enb; valid = vecs[i].valid; data_in = vecs[i].data;
      #1;
      chk($sformatf("ready[%0d]", i), ready, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      chk($sformatf("sout[%0d]", i), sout, vecs[i].exp_sout);
      chk($sformatf("frame[%0d]", i), frame, vecs[i].exp_frame);
      chk($sformatf("is_data[%0d]", i), is_data, vecs[i].exp_is_data);
      @(negedge clk);
    end

    // Reset mid-word: 8'h5A = 0101_1010, reset lands while bit 3 is on the line.
    w = 8'h5A;
    enb = 1'b1; valid = 1'b1; data_in = w;
    #1;
    chk("mw_ready", ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mw_sout[%0d]", k), sout, w[7-k]);
      @(negedge clk);
      valid = 1'b0;
    end
    rst = 1'b0;
    #1;
    chk("mw_rst_sout", sout, 1'b0);
    chk("mw_rst_is_data", is_data, 1'b0);
    chk("mw_rst_frame", frame, 1'b0);
    chk("mw_rst_ready", ready, 1'b0);
    repeat (2) @(negedge clk);

    // First word after release is the newly offered byte 8'h3C.
    w = 8'h3C;
    rst = 1'b1; valid = 1'b1; data_in = w;
    #1;
    chk("post_ready", ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_sout[%0d]", k), sout, w[7-k]);
      chk($sformatf("post_frame[%0d]", k), frame, (k == 0));
      chk($sformatf("post_is_data[%0d]", k), is_data, 1'b1);
      @(negedge clk);
      valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("tail_sout", sout, 1'b1);
    chk("tail_frame", frame, 1'b1);
    chk("tail_is_data", is_data, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
